// File: rtl/rvfpm_move_scoreboard.sv
// Shadow-pipeline scoreboard for rvfpm FMV.X.W / FMV.W.X moves.
// Expected values ride a stall-aware shift pipeline and are compared against the DUT at retirement.
module rvfpm_move_scoreboard #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PIPELINE_STAGES = 4,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned IW             = $clog2(PIPELINE_STAGES + 1)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  fp_rs1_data,
    input  logic [XLEN-1:0]  x_rs1_data,
    input  logic [XLEN-1:0]  data_toXReg,
    input  logic [XLEN-1:0]  data_toFReg,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [31:0]      last_err_instr,
    output logic [XLEN-1:0]  last_err_exp,
    output logic [XLEN-1:0]  last_err_got,
    output logic [IW-1:0]    inflight
);

    localparam int unsigned N = PIPELINE_STAGES;

    logic [N-1:0]     r_vld;
    logic [N-1:0]     r_mode;  // 0: FMV.X.W checks data_toXReg, 1: FMV.W.X checks data_toFReg
    logic [XLEN-1:0]  r_exp [N];
    logic [31:0]      r_ins [N];
    logic [IW-1:0]    r_inflight;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [31:0]      r_last_ins;
    logic [XLEN-1:0]  r_last_exp;
    logic [XLEN-1:0]  r_last_got;

    logic [4:0]       w_rs1;
    logic             w_base;
    logic             w_is_xw;
    logic             w_is_wx;
    logic             w_dec_vld;
    logic [XLEN-1:0]  w_dec_exp;
    logic [XLEN-1:0]  w_got;
    logic             w_adv;
    logic             w_cmp;
    logic             w_mis;
    logic [N-1:0]     w_vld_d;
    logic [IW-1:0]    w_pop;

    always_comb begin
        w_rs1     = instruction[19:15];
        w_base    = (instruction[6:0] == 7'b1010011) && (instruction[14:12] == 3'b000) &&
                    (instruction[24:20] == 5'd0) && ({27'd0, w_rs1} < NUM_REGS);
        w_is_xw   = w_base && (instruction[31:25] == 7'b1110000);
        w_is_wx   = w_base && (instruction[31:25] == 7'b1111000);
        w_dec_vld = instr_valid && (w_is_xw || w_is_wx);
        w_dec_exp = w_is_wx ? x_rs1_data : fp_rs1_data;
        w_got     = r_mode[N-1] ? data_toFReg : data_toXReg;
        w_adv     = enable && !flush;
        w_cmp     = w_adv && r_vld[N-1];
        w_mis     = w_cmp && (w_got != r_exp[N-1]);
    end

    always_comb begin
        w_vld_d = r_vld;
        if (flush) begin
            w_vld_d = '0;
        end else if (enable) begin
            w_vld_d[0] = w_dec_vld;
            for (int i = 1; i < N; i++) begin
                w_vld_d[i] = r_vld[i-1];
            end
        end
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + IW'(w_vld_d[i]);
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_vld       <= '0;
            r_mode      <= '0;
            for (int i = 0; i < N; i++) begin
                r_exp[i] <= '0;
                r_ins[i] <= '0;
            end
            r_inflight  <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_last_ins  <= '0;
            r_last_exp  <= '0;
            r_last_got  <= '0;
        end else begin
            r_vld       <= w_vld_d;
            r_inflight  <= w_pop;
            r_err_pulse <= w_mis;
            if (w_adv) begin
                r_mode[0] <= w_is_wx;
                r_exp[0]  <= w_dec_exp;
                r_ins[0]  <= instruction;
                for (int i = 1; i < N; i++) begin
                    r_mode[i] <= r_mode[i-1];
                    r_exp[i]  <= r_exp[i-1];
                    r_ins[i]  <= r_ins[i-1];
                end
            end
            if (w_cmp && (r_chk_cnt != '1)) begin
                r_chk_cnt <= r_chk_cnt + CNT_W'(1);
            end
            if (w_mis) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                r_last_ins <= r_ins[N-1];
                r_last_exp <= r_exp[N-1];
                r_last_got <= w_got;
            end
        end
    end

    assign err_pulse      = r_err_pulse;
    assign err_cnt        = r_err_cnt;
    assign chk_cnt        = r_chk_cnt;
    assign last_err_instr = r_last_ins;
    assign last_err_exp   = r_last_exp;
    assign last_err_got   = r_last_got;
    assign inflight       = r_inflight;

endmodule

// File: tb/tb_rvfpm_move_scoreboard.sv
// Directed bench for rvfpm_move_scoreboard: stimulus queues expected compares, a negedge monitor
// pops one entry each time the DUT reports a completed compare.
module tb_rvfpm_move_scoreboard;

    localparam logic [31:0] XW     = 32'hE000_8153;  // fmv.x.w x2, f1
    localparam logic [31:0] WX     = 32'hF000_8153;  // fmv.w.x f2, x1
    localparam logic [31:0] FADD   = 32'h0000_8153;  // fadd.s f2, f1, f0
    localparam logic [31:0] XW_RS2 = 32'hE010_8153;  // fmv.x.w encoding with rs2=1

    typedef struct {
        logic [31:0] ins;
        logic [31:0] exp;
        logic [31:0] got;
        bit          mis;
    } exp_t;

    logic        ck = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] fp_rs1_data;
    logic [31:0] x_rs1_data;
    logic [31:0] data_toXReg;
    logic [31:0] data_toFReg;

    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] chk_cnt;
    logic [31:0] last_err_instr;
    logic [31:0] last_err_exp;
    logic [31:0] last_err_got;
    logic [2:0]  inflight;

    logic        err_pulse2;
    logic [1:0]  err_cnt2;
    logic [1:0]  chk_cnt2;
    logic [31:0] last_err_instr2;
    logic [31:0] last_err_exp2;
    logic [31:0] last_err_got2;
    logic [2:0]  inflight2;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] prev_chk;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 ck = ~ck;

    rvfpm_move_scoreboard #(.NUM_REGS(32), .PIPELINE_STAGES(4), .XLEN(32), .CNT_W(16)) dut (
        .ck(ck), .rst(rst), .enable(enable), .flush(flush), .instr_valid(instr_valid),
        .instruction(instruction), .fp_rs1_data(fp_rs1_data), .x_rs1_data(x_rs1_data),
        .data_toXReg(data_toXReg), .data_toFReg(data_toFReg), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt), .last_err_instr(last_err_instr),
        .last_err_exp(last_err_exp), .last_err_got(last_err_got), .inflight(inflight)
    );

    rvfpm_move_scoreboard #(.NUM_REGS(32), .PIPELINE_STAGES(4), .XLEN(32), .CNT_W(2)) dut2 (
        .ck(ck), .rst(rst), .enable(enable), .flush(flush), .instr_valid(instr_valid),
        .instruction(instruction), .fp_rs1_data(fp_rs1_data), .x_rs1_data(x_rs1_data),
        .data_toXReg(data_toXReg), .data_toFReg(data_toFReg), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .chk_cnt(chk_cnt2), .last_err_instr(last_err_instr2),
        .last_err_exp(last_err_exp2), .last_err_got(last_err_got2), .inflight(inflight2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    endtask

    task automatic cyc(input logic en, input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] fp, input logic [31:0] xv, input logic [31:0] gx,
                       input logic [31:0] gf);
        enable      = en;
        flush       = fl;
        instr_valid = iv;
        instruction = ins;
        fp_rs1_data = fp;
        x_rs1_data  = xv;
        data_toXReg = gx;
        data_toFReg = gf;
        @(posedge ck);
        #1;
    endtask

    task automatic idle(input logic [31:0] gx, input logic [31:0] gf);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, gx, gf);
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] ex, input logic [31:0] got,
                        input bit mis);
        exp_t t;
        t.ins = ins;
        t.exp = ex;
        t.got = got;
        t.mis = mis;
        sb.push_back(t);
    endtask

    // Monitor: one scoreboard pop per observed chk_cnt step
    always @(negedge ck) begin
        if (rst !== 1'b1) begin
            prev_chk = '0;
        end else begin
            if (chk_cnt != prev_chk) begin
                if (sb.size() == 0) begin
                    chk("unexpected_compare", 32'(chk_cnt), 32'(prev_chk));
                end else begin
                    e = sb.pop_front();
                    chk("err_pulse", 32'(err_pulse), 32'(e.mis));
                    if (e.mis) begin
                        chk("last_err_instr", last_err_instr, e.ins);
                        chk("last_err_exp", last_err_exp, e.exp);
                        chk("last_err_got", last_err_got, e.got);
                    end
                end
            end else if (err_pulse) begin
                chk("spurious_pulse", 32'(err_pulse), 32'd0);
            end
            prev_chk = chk_cnt;
        end
    end

    logic [31:0] v [4];

    initial begin
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_chk_cnt", 32'(chk_cnt), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_last_exp", last_err_exp, 32'd0);
        rst = 1'b1;

        // T1: matching FMV.X.W, correct value only on the 4th edge
        push(XW, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'h3F80_0000, 32'h0, 32'h0, 32'h0);
        repeat (3) idle(32'h0, 32'h0);
        chk("t1_inflight_full", 32'(inflight), 32'd1);
        idle(32'h3F80_0000, 32'h0);
        chk("t1_chk_cnt", 32'(chk_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);

        // T2: FMV.W.X mismatch
        push(WX, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, WX, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        repeat (3) idle(32'h0, 32'h0);
        idle(32'h0, 32'hDEAD_BEEE);
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        idle(32'h0, 32'h0);
        chk("t2_pulse_one_cycle", 32'(err_pulse), 32'd0);

        // T3: stall for 3 cycles after two enabled edges
        push(XW, 32'h1234_5678, 32'h1234_5678, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        repeat (2) idle(32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, XW, 32'h5555_5555, 32'h0, 32'h1234_5678, 32'h0);
            chk("t3_inflight_stall", 32'(inflight), 32'd1);
            chk("t3_no_cmp_stall", 32'(chk_cnt), 32'd2);
        end
        idle(32'h0, 32'h0);
        chk("t3_no_cmp_edge6", 32'(chk_cnt), 32'd2);
        idle(32'h1234_5678, 32'h0);
        chk("t3_cmp_edge7", 32'(chk_cnt), 32'd3);

        // T4: three moves, then flush alongside a fourth
        cyc(1'b1, 1'b0, 1'b1, XW, 32'hA, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'hB, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'hC, 32'h0, 32'h0, 32'h0);
        chk("t4_inflight_pre", 32'(inflight), 32'd3);
        cyc(1'b1, 1'b1, 1'b1, XW, 32'hD, 32'h0, 32'hA, 32'h0);
        chk("t4_inflight_flush", 32'(inflight), 32'd0);
        idle(32'hB, 32'h0);
        idle(32'hC, 32'h0);
        repeat (4) idle(32'hD, 32'h0);
        chk("t4_chk_cnt", 32'(chk_cnt), 32'd3);
        chk("t4_inflight_post", 32'(inflight), 32'd0);

        // T6: non-move encodings around one valid FMV.X.W
        cyc(1'b1, 1'b0, 1'b1, FADD, 32'h1111_1111, 32'h0, 32'h0BAD_F00D, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, XW_RS2, 32'h2222_2222, 32'h0, 32'h0BAD_F00D, 32'h0);
        push(XW, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 32'h0);
        chk("t6_inflight", 32'(inflight), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, FADD, 32'h3333_3333, 32'h0, 32'h0BAD_F00D, 32'h0);
        repeat (6) idle(32'h0BAD_F00D, 32'h0);
        chk("t6_chk_cnt", 32'(chk_cnt), 32'd4);
        chk("t6_err_cnt", 32'(err_cnt), 32'd1);

        // T7: four back-to-back moves retiring on consecutive edges, third one wrong
        v[0] = 32'hA0A0_0001;
        v[1] = 32'hA0A0_0002;
        v[2] = 32'hA0A0_0003;
        v[3] = 32'hA0A0_0004;
        for (int i = 0; i < 4; i++) begin
            push(XW, v[i], (i == 2) ? (v[i] ^ 32'h1) : v[i], i == 2);
            cyc(1'b1, 1'b0, 1'b1, XW, v[i], 32'h0, 32'h0, 32'h0);
        end
        chk("t7_inflight", 32'(inflight), 32'd4);
        for (int i = 0; i < 4; i++) begin
            idle((i == 2) ? (v[i] ^ 32'h1) : v[i], 32'h0);
        end
        chk("t7_chk_cnt", 32'(chk_cnt), 32'd8);
        chk("t7_err_cnt", 32'(err_cnt), 32'd2);

        // T5: five more mismatches saturate the 2-bit counters
        for (int k = 0; k < 9; k++) begin
            if (k < 5) push(XW, 32'h100 + k, ~(32'h100 + k), 1'b1);
            cyc(1'b1, 1'b0, k < 5, XW, 32'h100 + k, 32'h0,
                (k >= 4) ? ~(32'h100 + (k - 4)) : 32'h0, 32'h0);
        end
        chk("t5_err_cnt_sat", 32'(err_cnt2), 32'd3);
        chk("t5_chk_cnt_sat", 32'(chk_cnt2), 32'd3);
        chk("t5_err_cnt_wide", 32'(err_cnt), 32'd7);
        cyc(1'b1, 1'b0, 1'b1, XW, 32'h77, 32'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, WX, 32'h0, 32'h88, 32'h0, 32'h0);
        rst = 1'b0;
        idle(32'h77, 32'h88);
        chk("t5_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("t5_rst_err_cnt2", 32'(err_cnt2), 32'd0);
        chk("t5_rst_chk_cnt", 32'(chk_cnt), 32'd0);
        chk("t5_rst_inflight", 32'(inflight), 32'd0);
        chk("t5_rst_last_instr", last_err_instr, 32'd0);
        chk("t5_rst_last_got", last_err_got, 32'd0);
        rst = 1'b1;
        repeat (6) idle(32'h77, 32'h88);
        chk("t5_post_rst_chk", 32'(chk_cnt), 32'd0);

        repeat (2) idle(32'h0, 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
